qc_signal_decimator: RTL and testbench
======================================

# qc_signal_decimator

Producer side of the Q-Control signal stream. It takes raw signed ADC samples, boxcar-averages them over 2^DECII_LEN2 samples, and rescales the result to SIGNAL_M_WIDTH. It then removes a programmable DC offset and saturates. The resulting signal words go out on an AXI-Stream master with tready back-pressure, buffered by a 4-entry FIFO, and feed the Q-Control delay/gain mixer input S_AXIS_SIGNAL_M.

## Interface

Parameters:
- ADC_WIDTH, 14, width of signed input samples
- SIGNAL_M_WIDTH, 16, width of signed output words (must be ≥ ADC_WIDTH)
- DECII_LEN2, 2, log2 of decimation factor; legal range 0..8
- FIFO_LEN2, 2, log2 of output FIFO depth (depth 4)

Ports (one clock; reset is synchronous and active-high):
- a_clk  in  1  sole clock; all logic on rising edge
- a_rst  in  1  synchronous active-high reset
- S_AXIS_ADC_tdata  in  ADC_WIDTH  signed ADC sample
- S_AXIS_ADC_tvalid  in  1  sample qualifier; no tready, every valid sample is consumed
- enable  in  1  1 = accumulate and emit; 0 = hold accumulator cleared
- dc_offset  in  16  signed, in output LSBs; subtracted after scaling
- clear_overflow  in  1  single-cycle pulse; clears overflow and drop_count
- M_AXIS_tdata  out  SIGNAL_M_WIDTH  signed averaged word (FIFO head)
- M_AXIS_tvalid  out  1  FIFO non-empty
- M_AXIS_tready  in  1  consumer ready
- fill_level  out  FIFO_LEN2+1  current FIFO occupancy, 0..4
- overflow  out  1  sticky: at least one word dropped
- drop_count  out  16  dropped-word count, saturates at 0xFFFF

## Operation

- Accumulator: signed, ADC_WIDTH+DECII_LEN2 bits. Sample counter: DECII_LEN2 bits.
- On each edge with enable=1 and S_AXIS_ADC_tvalid=1, add the sample to the accumulator and increment the counter.
- When the counter wraps, the sum including the current sample is latched into sum_reg, the accumulator restarts from 0, and the stage-2 valid flag is set.
- Stage 2 computes scaled = (sum_reg <<< (SIGNAL_M_WIDTH−ADC_WIDTH)) >>> DECII_LEN2. The right shift is arithmetic and floors.
- Stage 2 then computes diff = scaled − sign-extended dc_offset, in SIGNAL_M_WIDTH+2 bits, and saturates diff to [−2^(SIGNAL_M_WIDTH−1), 2^(SIGNAL_M_WIDTH−1)−1]. The saturated word is pushed into the FIFO.
- DECII_LEN2=0: every valid sample produces one word.
- enable=0:
  - Accumulator, counter, and stage-2 valid flag are cleared.
  - The FIFO keeps draining.
  - A partial average is discarded, never emitted.
- FIFO:
  - Pop when M_AXIS_tvalid && M_AXIS_tready.
  - Push when the stage-2 word is valid.
  - Push and pop in the same cycle leave the occupancy unchanged and are never a drop, including when the FIFO is full.
  - Push while full with no pop: the word is discarded, overflow is set, and drop_count increments, saturating at 0xFFFF.
  - Pop while empty cannot occur, because tvalid=0.
- M_AXIS_tdata is the head entry. It holds stable while tvalid=1 and tready=0 (AXIS rule).
- clear_overflow:
  - Clears overflow and drop_count at the next edge.
  - If a drop happens in the same cycle, the drop wins: overflow=1 and drop_count=1.

## Timing

- Reset values: M_AXIS_tvalid=0, M_AXIS_tdata=0, fill_level=0, overflow=0, drop_count=0. Accumulator, counter, sum_reg, and stage flags are all 0.
- Reset mid-operation discards the partial sum and all FIFO contents.
- Latency, with the FIFO empty:
  - Edge E0 samples the final sample of a group.
  - Edge E1 writes the FIFO.
  - M_AXIS_tvalid=1 in the cycle after E1.
  - If tready=1, the word pops at E2.
- Throughput: one word per 2^DECII_LEN2 valid samples. A sample is accepted on every cycle that tvalid is high; there are no bubbles.
- fill_level, overflow, and drop_count update on the same edge as the push or pop that changes them.
- dc_offset is sampled in stage 2 (edge E1), not stage 1.
- enable falling at E0 cancels the in-flight stage-2 word only if it has not yet been written. The word produced at E0 is still pushed at E1.

## Test plan

- **Constant input.** DECII_LEN2=2, dc_offset=0, constant 1000, tvalid continuous, tready=1. Required: one word per 4 samples, value 4000; first tvalid two edges after the 4th sample.
- **Offset and rounding.** Samples 1000,1000,1001,1002 (sum 4003) with dc_offset=100. Required: output 3903. Samples −1,0,0,0. Required: output −1 (floor).
- **Saturation.** Constant 8191 with dc_offset=−100. Required: 32767. Constant −8192 with dc_offset=+100. Required: −32768.
- **Back-pressure and overflow.** tready=0 for 6 output periods, then tready=1. Required: fill_level reaches 4; the first 4 words are emitted in order; overflow=1; drop_count=2. A clear_overflow pulse then returns both to 0.
- **Full FIFO with simultaneous push and pop.** FIFO full, tready=1 on the push cycle. Required: no drop and fill_level stays 4.
- **Enable and reset mid-group.** Drop enable after 2 of 4 samples, then re-enable. Required: the next output averages 4 fresh samples. Assert a_rst with 3 words queued. Required: tvalid=0 and fill_level=0 on the next cycle.

Source files
------------

// File: rtl/qc_signal_decimator.sv
// qc_signal_decimator: boxcar-averages signed ADC samples over 2^DECII_LEN2
// samples, rescales to SIGNAL_M_WIDTH, subtracts dc_offset with saturation and
// queues the words in a small FIFO feeding an AXI-Stream master.
// Latency: last sample of a group at edge E0, FIFO write at E1, tvalid after E1.
// Backpressure: M_AXIS_tready stalls the FIFO; a push into a full FIFO with no
// pop is dropped and recorded in overflow / drop_count.
// Ports:
//   a_clk, a_rst                 clock, synchronous active-high reset
//   S_AXIS_ADC_tdata/_tvalid     signed input samples (always accepted)
//   enable                       0 clears the accumulator, discards partial groups
//   dc_offset                    signed offset in output LSBs
//   clear_overflow               clears overflow and drop_count
//   M_AXIS_tdata/_tvalid/_tready output stream (FIFO head)
//   fill_level, overflow, drop_count  FIFO status
module qc_signal_decimator #(
  parameter int ADC_WIDTH      = 14,
  parameter int SIGNAL_M_WIDTH = 16,
  parameter int DECII_LEN2     = 2,
  parameter int FIFO_LEN2      = 2
) (
  input  logic                      a_clk,
  input  logic                      a_rst,
  input  logic [ADC_WIDTH-1:0]      S_AXIS_ADC_tdata,
  input  logic                      S_AXIS_ADC_tvalid,
  input  logic                      enable,
  input  logic [15:0]               dc_offset,
  input  logic                      clear_overflow,
  output logic [SIGNAL_M_WIDTH-1:0] M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic [FIFO_LEN2:0]        fill_level,
  output logic                      overflow,
  output logic [15:0]               drop_count
);

  localparam int ACC_W  = ADC_WIDTH + DECII_LEN2;
  localparam int CNT_W  = (DECII_LEN2 > 0) ? DECII_LEN2 : 1;
  localparam int SHL    = SIGNAL_M_WIDTH - ADC_WIDTH;
  localparam int SC_W   = ACC_W + SHL;
  // Wide enough for both the scaled word and the 16-bit offset, plus headroom.
  localparam int DIFF_W = ((SIGNAL_M_WIDTH > 16) ? SIGNAL_M_WIDTH : 16) + 2;
  localparam int DEPTH  = 1 << FIFO_LEN2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECII_LEN2) - 1);
  localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'((1 << (SIGNAL_M_WIDTH - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] SAT_MIN = -SAT_MAX - DIFF_W'(1);

  // ---------------- stage 1: accumulate ----------------
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, acc_sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    s2_vld_q, s2_vld_d;

  assign acc_sum = acc_q + ACC_W'($signed(S_AXIS_ADC_tdata));

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    s2_vld_d = 1'b0;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (S_AXIS_ADC_tvalid) begin
      if (cnt_q == CNT_LAST) begin
        // Group complete: hand the full sum (incl. this sample) to stage 2.
        sum_d    = acc_sum;
        acc_d    = '0;
        cnt_d    = '0;
        s2_vld_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------- stage 2: scale, offset, saturate ----------------
  logic signed [SC_W-1:0]           sum_shl, sum_sc;
  logic signed [SIGNAL_M_WIDTH-1:0] scaled, word;
  logic signed [DIFF_W-1:0]         diff;

  always_comb begin
    sum_shl = SC_W'(sum_q) <<< SHL;
    sum_sc  = sum_shl >>> DECII_LEN2;   // arithmetic, floors toward -inf
    // The average never exceeds the ADC range, so the low bits hold it exactly.
    scaled  = sum_sc[SIGNAL_M_WIDTH-1:0];
    diff    = DIFF_W'(scaled) - DIFF_W'($signed(dc_offset));
    if (diff > SAT_MAX)      word = SAT_MAX[SIGNAL_M_WIDTH-1:0];
    else if (diff < SAT_MIN) word = SAT_MIN[SIGNAL_M_WIDTH-1:0];
    else                     word = diff[SIGNAL_M_WIDTH-1:0];
  end

  // ---------------- output FIFO ----------------
  logic [SIGNAL_M_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_LEN2-1:0]      wr_q, rd_q;
  logic [FIFO_LEN2:0]        lvl_q;
  logic                      ovf_q;
  logic [15:0]               drop_q;
  logic                      push, pop, full, wr_en, drop;

  assign push  = s2_vld_q;
  assign pop   = M_AXIS_tvalid && M_AXIS_tready;
  assign full  = (lvl_q == (FIFO_LEN2 + 1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      s2_vld_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      s2_vld_q <= s2_vld_d;
      if (wr_en) begin
        mem_q[wr_q] <= word;
        wr_q        <= wr_q + FIFO_LEN2'(1);
      end
      if (pop) rd_q <= rd_q + FIFO_LEN2'(1);
      if (wr_en && !pop)      lvl_q <= lvl_q + (FIFO_LEN2 + 1)'(1);
      else if (!wr_en && pop) lvl_q <= lvl_q - (FIFO_LEN2 + 1)'(1);
      // A drop in the clearing cycle wins and counts as the first drop.
      if (drop) begin
        ovf_q <= 1'b1;
        if (clear_overflow)       drop_q <= 16'd1;
        else if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end else if (clear_overflow) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  assign M_AXIS_tvalid = (lvl_q != '0);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? mem_q[rd_q] : '0;
  assign fill_level    = lvl_q;
  assign overflow      = ovf_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_qc_signal_decimator.sv
module tb_qc_signal_decimator;

  logic        a_clk = 1'b0;
  logic        a_rst;
  logic [13:0] S_AXIS_ADC_tdata;
  logic        S_AXIS_ADC_tvalid;
  logic        enable;
  logic [15:0] dc_offset;
  logic        clear_overflow;
  logic [15:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [2:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_count;

  always #5 a_clk = ~a_clk;

  qc_signal_decimator #(
    .ADC_WIDTH(14), .SIGNAL_M_WIDTH(16), .DECII_LEN2(2), .FIFO_LEN2(2)
  ) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .S_AXIS_ADC_tdata(S_AXIS_ADC_tdata), .S_AXIS_ADC_tvalid(S_AXIS_ADC_tvalid),
    .enable(enable), .dc_offset(dc_offset), .clear_overflow(clear_overflow),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  typedef struct {
    int s0, s1, s2, s3;
    int dc;
    int exp;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic drive(input int v);
    S_AXIS_ADC_tdata  = 14'(v);
    S_AXIS_ADC_tvalid = 1'b1;
    tick();
  endtask

  // Four samples; dc_offset changes after the first one so the previous
  // group's word (written on this group's first edge) still sees its own offset.
  task automatic group(input int a, input int b, input int c, input int d,
                       input int dc, input int e, input bit keep);
    drive(a);
    dc_offset = 16'(dc);
    drive(b);
    drive(c);
    if (keep) exp_q.push_back(e);
    drive(d);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || M_AXIS_tvalid) && k < 100) begin
      tick();
      k++;
    end
    chk({nm, "_pending"}, exp_q.size(), 0);
    @(negedge a_clk);
    chk({nm, "_fill"}, int'(fill_level), 0);
  endtask

  // Scoreboard: every accepted output word is matched against the queue head.
  always @(negedge a_clk) begin
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %0d required none", $signed(M_AXIS_tdata));
      end else begin
        chk("out_word", int'($signed(M_AXIS_tdata)), exp_q.pop_front());
      end
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1000, 1000, 1000, 1000, 0, 4000};
    vecs[1] = '{1000, 1000, 1001, 1002, 100, 3903};
    vecs[2] = '{-1, 0, 0, 0, 0, -1};
    vecs[3] = '{8191, 8191, 8191, 8191, -100, 32767};
    vecs[4] = '{-8192, -8192, -8192, -8192, 100, -32768};
    vecs[5] = '{100, 200, 300, 400, -50, 1050};
    vecs[6] = '{0, 0, 0, 0, 32767, -32767};
    vecs[7] = '{0, 0, 0, 0, -32768, 32767};

    a_rst = 1'b1; S_AXIS_ADC_tdata = '0; S_AXIS_ADC_tvalid = 1'b0;
    enable = 1'b0; dc_offset = '0; clear_overflow = 1'b0; M_AXIS_tready = 1'b0;
    repeat (3) tick();
    @(negedge a_clk);
    chk("rst_tvalid", int'(M_AXIS_tvalid), 0);
    chk("rst_tdata", int'(M_AXIS_tdata), 0);
    chk("rst_fill", int'(fill_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop", int'(drop_count), 0);
    a_rst = 1'b0;
    enable = 1'b1;
    tick();

    // Latency and hold under tready=0.
    group(1000, 1000, 1000, 1000, 0, 4000, 1'b1);
    S_AXIS_ADC_tvalid = 1'b0;
    @(negedge a_clk);
    chk("lat_e0_tvalid", int'(M_AXIS_tvalid), 0);
    tick();
    @(negedge a_clk);
    chk("lat_e1_tvalid", int'(M_AXIS_tvalid), 1);
    chk("lat_e1_fill", int'(fill_level), 1);
    chk("lat_e1_data", int'($signed(M_AXIS_tdata)), 4000);
    repeat (3) tick();
    @(negedge a_clk);
    chk("hold_data", int'($signed(M_AXIS_tdata)), 4000);
    M_AXIS_tready = 1'b1;
    drain("lat");

    // Table-driven groups, back to back.
    foreach (vecs[i])
      group(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].dc, vecs[i].exp, 1'b1);
    S_AXIS_ADC_tvalid = 1'b0;
    repeat (2) tick();
    drain("table");

    // Back-pressure: six words into a four-deep FIFO.
    M_AXIS_tready = 1'b0;
    for (int g = 0; g < 6; g++)
      group(100 * (g + 1), 100 * (g + 1), 100 * (g + 1), 100 * (g + 1), 0,
            400 * (g + 1), g < 4);
    S_AXIS_ADC_tvalid = 1'b0;
    repeat (2) tick();
    @(negedge a_clk);
    chk("bp_fill", int'(fill_level), 4);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_drop", int'(drop_count), 2);
    M_AXIS_tready = 1'b1;
    drain("bp");
    chk("bp_overflow_sticky", int'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    @(negedge a_clk);
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_drop", int'(drop_count), 0);

    // Full FIFO with push and pop on the same edge.
    M_AXIS_tready = 1'b0;
    for (int g = 0; g < 4; g++)
      group(200 * (g + 1), 200 * (g + 1), 200 * (g + 1), 200 * (g + 1), 0,
            800 * (g + 1), 1'b1);
    group(1, 1, 1, 1, 0, 4, 1'b1);
    S_AXIS_ADC_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    tick();
    M_AXIS_tready = 1'b0;
    @(negedge a_clk);
    chk("pp_fill", int'(fill_level), 4);
    chk("pp_overflow", int'(overflow), 0);
    chk("pp_drop", int'(drop_count), 0);
    M_AXIS_tready = 1'b1;
    drain("pp");

    // Enable dropped mid-group: partial sum must not leak.
    drive(5000);
    drive(5000);
    enable = 1'b0;
    drive(5000);
    drive(5000);
    enable = 1'b1;
    group(100, 100, 100, 100, 0, 400, 1'b1);
    S_AXIS_ADC_tvalid = 1'b0;
    repeat (2) tick();
    drain("en_mid");

    // Enable falling right after the last sample: word still emitted.
    group(250, 250, 250, 250, 0, 1000, 1'b1);
    enable = 1'b0;
    S_AXIS_ADC_tvalid = 1'b0;
    repeat (2) tick();
    drain("en_e0");
    for (int i = 0; i < 4; i++) drive(700);
    S_AXIS_ADC_tvalid = 1'b0;
    repeat (2) tick();
    drain("en_off");
    enable = 1'b1;

    // Reset with three words queued and a partial group in the accumulator.
    M_AXIS_tready = 1'b0;
    for (int g = 0; g < 3; g++)
      group(300, 300, 300, 300, 0, 1200, 1'b0);
    drive(4000);
    drive(4000);
    S_AXIS_ADC_tvalid = 1'b0;
    repeat (2) tick();
    @(negedge a_clk);
    chk("rstmid_fill_before", int'(fill_level), 3);
    a_rst = 1'b1;
    tick();
    @(negedge a_clk);
    chk("rstmid_tvalid", int'(M_AXIS_tvalid), 0);
    chk("rstmid_fill", int'(fill_level), 0);
    a_rst = 1'b0;
    group(300, 300, 300, 300, 0, 1200, 1'b1);
    S_AXIS_ADC_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (2) tick();
    drain("rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
